// File: rtl/mips_pkg.sv
// Shared opcode/funct encodings and control types for the single-cycle MIPS core.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_ctrl_t;

  typedef struct packed {
    logic      reg_dst;
    logic      alu_src;
    logic      mem_to_reg;
    logic      reg_write;
    logic      mem_write;
    logic      branch;
    logic      jump;
    alu_ctrl_t alu_ctrl;
  } ctrl_t;

endpackage

// File: rtl/mips_alu.sv
// 32-bit ALU: wrapping add/sub, bitwise and/or, signed set-less-than, zero flag.
module mips_alu
  import mips_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_ctrl_t   alu_ctrl,
  output logic [31:0] result,
  output logic        zero
);

  always_comb begin
    result = '0;
    case (alu_ctrl)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_SLT: result = {31'd0, $signed(a) < $signed(b)};
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/mips_control.sv
// Main decoder plus ALU control; anything unrecognised decodes to a nop
// (no register write, no memory write, sequential PC).
module mips_control
  import mips_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl          = '0;
    ctrl.alu_ctrl = ALU_ADD;
    case (opcode)
      OP_RTYPE: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
        case (funct)
          FN_ADD:  ctrl.alu_ctrl = ALU_ADD;
          FN_SUB:  ctrl.alu_ctrl = ALU_SUB;
          FN_AND:  ctrl.alu_ctrl = ALU_AND;
          FN_OR:   ctrl.alu_ctrl = ALU_OR;
          FN_SLT:  ctrl.alu_ctrl = ALU_SLT;
          default: ctrl.reg_write = 1'b0;
        endcase
      end
      OP_ADDI: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      OP_LW: begin
        ctrl.alu_src    = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      OP_SW: begin
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      OP_BEQ: begin
        ctrl.branch   = 1'b1;
        ctrl.alu_ctrl = ALU_SUB;
      end
      OP_J:    ctrl.jump = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_dmem.sv
// Little-endian byte-array data memory with word access; address bits [1:0] are
// ignored, out-of-range reads return 0 and out-of-range writes are dropped.
module mips_dmem #(
  parameter int DMEM_BYTES = 128
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  output logic [31:0] rdata
);

  localparam int AW = $clog2(DMEM_BYTES);

  logic [7:0]    memory [0:DMEM_BYTES-1];
  logic          in_range;
  logic [AW-3:0] word;
  logic          unused_bits;

  assign in_range    = (addr[31:AW] == '0);
  assign word        = addr[AW-1:2];
  assign unused_bits = ^addr[1:0];

  assign rdata = in_range ? {memory[{word, 2'd3}], memory[{word, 2'd2}],
                             memory[{word, 2'd1}], memory[{word, 2'd0}]} : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DMEM_BYTES; i++) memory[i] <= '0;
    end else if (we && in_range) begin
      memory[{word, 2'd0}] <= wdata[7:0];
      memory[{word, 2'd1}] <= wdata[15:8];
      memory[{word, 2'd2}] <= wdata[23:16];
      memory[{word, 2'd3}] <= wdata[31:24];
    end
  end

endmodule

// File: rtl/mips_imem.sv
// Word-addressed instruction ROM, read combinationally; the image is preloaded
// into memory by the environment and words outside the array read as 0 (nop).
module mips_imem #(
  parameter int IMEM_WORDS = 64
) (
  input  logic [31:0] addr,
  output logic [31:0] instr
);

  localparam int IW = $clog2(IMEM_WORDS);

  logic [31:0] memory [0:IMEM_WORDS-1] = '{default: '0};
  logic        in_range;
  logic        unused_bits;

  assign in_range    = (addr[31:2] < 30'(IMEM_WORDS));
  assign instr       = in_range ? memory[addr[IW+1:2]] : '0;
  assign unused_bits = ^addr[1:0];

endmodule

// File: rtl/mips_pc.sv
// Program counter register; cleared asynchronously, loads the next PC every edge.
module mips_pc (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_next,
  output logic [31:0] pc_out
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_out <= '0;
    else        pc_out <= pc_next;
  end

endmodule

// File: rtl/mips_regfile.sv
// 32x32 register file: two combinational read ports, one write port, $0 hardwired to 0.
module mips_regfile (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  wa,
  input  logic        we,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);

  logic [31:0] register [0:31];

  assign rd1 = (ra1 == 5'd0) ? '0 : register[ra1];
  assign rd2 = (ra2 == 5'd0) ? '0 : register[ra2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) register[i] <= '0;
    end else if (we && (wa != 5'd0)) begin
      register[wa] <= wd;
    end
  end

endmodule

// File: rtl/mips_single_cycle_cpu.sv
// Single-cycle MIPS subset core: fetch, decode, execute, memory and write-back
// all complete in one clock; this level holds only muxes, sign extension and next-PC.
module mips_single_cycle_cpu
  import mips_pkg::*;
#(
  parameter string IMEM_FILE  = "instructions.hex",
  parameter int    IMEM_WORDS = 64,
  parameter int    DMEM_BYTES = 128
) (
  input logic clk,
  input logic rst_n
);

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] pc_next;
  logic [31:0] instr;
  logic [31:0] simm;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic [31:0] alu_b;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic [31:0] mem_rdata;
  logic [31:0] wb_data;
  logic [4:0]  wr_reg;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  ctrl_t       ctrl;

  mips_pc PC (
    .clk     (clk),
    .rst_n   (rst_n),
    .pc_next (pc_next),
    .pc_out  (pc)
  );

  mips_imem #(.IMEM_WORDS(IMEM_WORDS)) Instruction_Memory (
    .addr  (pc),
    .instr (instr)
  );

  mips_control Control (
    .opcode (instr[31:26]),
    .funct  (instr[5:0]),
    .ctrl   (ctrl)
  );

  mips_regfile Register_File (
    .clk   (clk),
    .rst_n (rst_n),
    .ra1   (instr[25:21]),
    .ra2   (instr[20:16]),
    .wa    (wr_reg),
    .we    (ctrl.reg_write),
    .wd    (wb_data),
    .rd1   (rd1),
    .rd2   (rd2)
  );

  mips_alu ALU (
    .a        (rd1),
    .b        (alu_b),
    .alu_ctrl (ctrl.alu_ctrl),
    .result   (alu_result),
    .zero     (alu_zero)
  );

  mips_dmem #(.DMEM_BYTES(DMEM_BYTES)) Data_Memory (
    .clk   (clk),
    .rst_n (rst_n),
    .addr  (alu_result),
    .wdata (rd2),
    .we    (ctrl.mem_write),
    .rdata (mem_rdata)
  );

  assign simm    = {{16{instr[15]}}, instr[15:0]};
  assign wr_reg  = ctrl.reg_dst ? instr[15:11] : instr[20:16];
  assign alu_b   = ctrl.alu_src ? simm : rd2;
  assign wb_data = ctrl.mem_to_reg ? mem_rdata : alu_result;

  // beq compares via ALU subtraction, so zero means rs == rt
  assign pc_plus4      = pc + 32'd4;
  assign branch_target = pc_plus4 + {simm[29:0], 2'b00};
  assign jump_target   = {pc_plus4[31:28], instr[25:0], 2'b00};
  assign pc_next       = ctrl.jump                  ? jump_target   :
                         (ctrl.branch && alu_zero)  ? branch_target : pc_plus4;

endmodule

// File: tb/tb_mips_single_cycle_cpu.sv
// Directed and randomized program tests for mips_single_cycle_cpu against an
// instruction-level reference interpreter kept in the bench.
module tb_mips_single_cycle_cpu;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  mips_single_cycle_cpu #(
    .IMEM_FILE  ("instructions.hex"),
    .IMEM_WORDS (64),
    .DMEM_BYTES (128)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] prog_mem [64];
  logic [31:0] m_reg    [32];
  logic [7:0]  m_mem    [128];
  logic [31:0] m_pc;

  function automatic logic [31:0] r_ins(input logic [5:0] fn, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] j_ins(input logic [25:0] target);
    return {6'h02, target};
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < 64; i++) prog_mem[i] = 32'd0;
  endtask

  task automatic model_reset();
    m_pc = 32'd0;
    for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
    for (int i = 0; i < 128; i++) m_mem[i] = 8'd0;
  endtask

  task automatic set_reg(input logic [4:0] r, input logic [31:0] v);
    if (r != 5'd0) m_reg[r] = v;
  endtask

  // Reference interpreter: one architectural instruction per call
  task automatic model_step();
    logic [31:0] ins, a, b, simm, npc, addr;
    logic [4:0]  rs, rt, rd;
    ins  = (m_pc < 32'd256) ? prog_mem[m_pc[7:2]] : 32'd0;
    rs   = ins[25:21];
    rt   = ins[20:16];
    rd   = ins[15:11];
    a    = m_reg[rs];
    b    = m_reg[rt];
    simm = {{16{ins[15]}}, ins[15:0]};
    npc  = m_pc + 32'd4;
    addr = (a + simm) & 32'hFFFF_FFFC;
    case (ins[31:26])
      6'h00: case (ins[5:0])
        6'h20:   set_reg(rd, a + b);
        6'h22:   set_reg(rd, a - b);
        6'h24:   set_reg(rd, a & b);
        6'h25:   set_reg(rd, a | b);
        6'h2A:   set_reg(rd, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
        default: ;
      endcase
      6'h08: set_reg(rt, a + simm);
      6'h23: begin
        if (addr < 32'd128)
          set_reg(rt, {m_mem[{addr[6:2], 2'd3}], m_mem[{addr[6:2], 2'd2}],
                       m_mem[{addr[6:2], 2'd1}], m_mem[{addr[6:2], 2'd0}]});
        else
          set_reg(rt, 32'd0);
      end
      6'h2B: begin
        if (addr < 32'd128) begin
          m_mem[{addr[6:2], 2'd0}] = b[7:0];
          m_mem[{addr[6:2], 2'd1}] = b[15:8];
          m_mem[{addr[6:2], 2'd2}] = b[23:16];
          m_mem[{addr[6:2], 2'd3}] = b[31:24];
        end
      end
      6'h04: if (a == b) npc = npc + (simm << 2);
      6'h02: npc = {npc[31:28], ins[25:0], 2'b00};
      default: ;
    endcase
    m_pc = npc;
  endtask

  task automatic load_and_restart();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 64; i++) dut.Instruction_Memory.memory[i] = prog_mem[i];
    model_reset();
    #1;
    rst_n = 1'b1;
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      model_step();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_prog();
    #1;
    for (int i = 0; i < 64; i++) dut.Instruction_Memory.memory[i] = prog_mem[i];
    model_reset();
    #10;
    n_checks++;
    if (dut.PC.pc_out !== 32'd0)
      $display("FAIL reset_pc: got %h expected %h", dut.PC.pc_out, 32'd0);
    else n_pass++;
    for (int i = 0; i < 32; i++) begin
      n_checks++;
      if (dut.Register_File.register[i] !== 32'd0)
        $display("FAIL reset_reg%0d: got %h expected 0", i, dut.Register_File.register[i]);
      else n_pass++;
    end
    for (int i = 0; i < 32; i++) begin
      n_checks++;
      if (dut.Data_Memory.memory[i] !== 8'd0)
        $display("FAIL reset_mem%0d: got %h expected 0", i, dut.Data_Memory.memory[i]);
      else n_pass++;
    end
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (dut.PC.pc_out !== 32'd4)
      $display("FAIL reset_first_edge_pc: got %h expected %h", dut.PC.pc_out, 32'd4);
    else n_pass++;
  endtask

  task automatic test_arith();
    logic [31:0] exp_val [5] = '{32'd10, 32'hFFFF_FFFD, 32'd7, 32'd13, 32'd1};
    clear_prog();
    prog_mem[0] = i_ins(6'h08, 5'd0, 5'd8, 16'd10);
    prog_mem[1] = i_ins(6'h08, 5'd0, 5'd9, 16'hFFFD);
    prog_mem[2] = r_ins(6'h20, 5'd8, 5'd9, 5'd10);
    prog_mem[3] = r_ins(6'h22, 5'd8, 5'd9, 5'd11);
    prog_mem[4] = r_ins(6'h2A, 5'd9, 5'd8, 5'd12);
    load_and_restart();
    step(5);
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (dut.Register_File.register[8+i] !== exp_val[i])
        $display("FAIL arith_reg%0d: got %h expected %h", 8 + i,
                 dut.Register_File.register[8+i], exp_val[i]);
      else n_pass++;
    end
    n_checks++;
    if (dut.PC.pc_out !== 32'd20)
      $display("FAIL arith_pc: got %h expected %h", dut.PC.pc_out, 32'd20);
    else n_pass++;
  endtask

  task automatic test_logic_nop();
    logic [4:0]  idx     [6] = '{5'd13, 5'd14, 5'd0, 5'd10, 5'd15, 5'd9};
    logic [31:0] exp_val [6] = '{32'd8, 32'd14, 32'd0, 32'd0, 32'd0, 32'd10};
    clear_prog();
    prog_mem[0] = i_ins(6'h08, 5'd0, 5'd8, 16'h000C);
    prog_mem[1] = i_ins(6'h08, 5'd0, 5'd9, 16'h000A);
    prog_mem[2] = r_ins(6'h24, 5'd8, 5'd9, 5'd13);
    prog_mem[3] = r_ins(6'h25, 5'd8, 5'd9, 5'd14);
    prog_mem[4] = i_ins(6'h08, 5'd0, 5'd0, 16'd5);
    prog_mem[5] = i_ins(6'h3F, 5'd0, 5'd10, 16'h1234);
    prog_mem[6] = r_ins(6'h27, 5'd8, 5'd9, 5'd15);
    load_and_restart();
    step(7);
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (dut.Register_File.register[idx[i]] !== exp_val[i])
        $display("FAIL logic_reg%0d: got %h expected %h", idx[i],
                 dut.Register_File.register[idx[i]], exp_val[i]);
      else n_pass++;
    end
    n_checks++;
    if (dut.PC.pc_out !== 32'd28)
      $display("FAIL logic_pc: got %h expected %h", dut.PC.pc_out, 32'd28);
    else n_pass++;
  endtask

  task automatic test_mem();
    int          bidx [7] = '{4, 5, 6, 7, 8, 9, 0};
    logic [7:0]  bexp [7] = '{8'h34, 8'h12, 8'h00, 8'h00, 8'h34, 8'h12, 8'h00};
    logic [4:0]  ridx [3] = '{5'd16, 5'd8, 5'd18};
    logic [31:0] rexp [3] = '{32'd4660, 32'd0, 32'd4660};
    clear_prog();
    prog_mem[0] = i_ins(6'h08, 5'd0, 5'd8, 16'h1234);
    prog_mem[1] = i_ins(6'h2B, 5'd0, 5'd8, 16'd4);
    prog_mem[2] = i_ins(6'h23, 5'd0, 5'd16, 16'd4);
    prog_mem[3] = i_ins(6'h2B, 5'd0, 5'd8, 16'h0080);
    prog_mem[4] = i_ins(6'h23, 5'd0, 5'd8, 16'h0080);
    prog_mem[5] = i_ins(6'h23, 5'd0, 5'd18, 16'd7);
    prog_mem[6] = i_ins(6'h2B, 5'd0, 5'd16, 16'd10);
    load_and_restart();
    step(7);
    for (int i = 0; i < 7; i++) begin
      n_checks++;
      if (dut.Data_Memory.memory[bidx[i]] !== bexp[i])
        $display("FAIL mem_byte%0d: got %h expected %h", bidx[i],
                 dut.Data_Memory.memory[bidx[i]], bexp[i]);
      else n_pass++;
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (dut.Register_File.register[ridx[i]] !== rexp[i])
        $display("FAIL mem_reg%0d: got %h expected %h", ridx[i],
                 dut.Register_File.register[ridx[i]], rexp[i]);
      else n_pass++;
    end
  endtask

  task automatic test_branch_jump();
    logic [31:0] exp_pc [6] = '{32'h08, 32'h0C, 32'h10, 32'h40, 32'h44, 32'h40};
    clear_prog();
    prog_mem[0]  = i_ins(6'h04, 5'd0, 5'd0, 16'd1);
    prog_mem[1]  = i_ins(6'h08, 5'd0, 5'd9, 16'd1);
    prog_mem[2]  = i_ins(6'h08, 5'd0, 5'd8, 16'd3);
    prog_mem[3]  = i_ins(6'h04, 5'd8, 5'd0, 16'd5);
    prog_mem[4]  = j_ins(26'h10);
    prog_mem[16] = i_ins(6'h08, 5'd0, 5'd10, 16'd7);
    prog_mem[17] = i_ins(6'h04, 5'd0, 5'd0, 16'hFFFE);
    load_and_restart();
    for (int i = 0; i < 6; i++) begin
      step(1);
      n_checks++;
      if (dut.PC.pc_out !== exp_pc[i])
        $display("FAIL branch_pc_step%0d: got %h expected %h", i, dut.PC.pc_out, exp_pc[i]);
      else n_pass++;
    end
    n_checks++;
    if (dut.Register_File.register[9] !== 32'd0)
      $display("FAIL branch_skipped_reg9: got %h expected 0", dut.Register_File.register[9]);
    else n_pass++;
    n_checks++;
    if (dut.Register_File.register[10] !== 32'd7)
      $display("FAIL branch_reg10: got %h expected 7", dut.Register_File.register[10]);
    else n_pass++;
  endtask

  task automatic test_midrun_reset();
    clear_prog();
    prog_mem[0] = i_ins(6'h08, 5'd0, 5'd8, 16'h1234);
    prog_mem[1] = i_ins(6'h2B, 5'd0, 5'd8, 16'd4);
    prog_mem[2] = i_ins(6'h23, 5'd0, 5'd16, 16'd4);
    load_and_restart();
    step(3);
    n_checks++;
    if (dut.Data_Memory.memory[4] !== 8'h34)
      $display("FAIL midrun_pre_mem4: got %h expected 34", dut.Data_Memory.memory[4]);
    else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (dut.PC.pc_out !== 32'd0)
      $display("FAIL midrun_pc: got %h expected 0", dut.PC.pc_out);
    else n_pass++;
    n_checks++;
    if (dut.Register_File.register[16] !== 32'd0)
      $display("FAIL midrun_reg16: got %h expected 0", dut.Register_File.register[16]);
    else n_pass++;
    n_checks++;
    if (dut.Data_Memory.memory[4] !== 8'h00)
      $display("FAIL midrun_mem4: got %h expected 0", dut.Data_Memory.memory[4]);
    else n_pass++;
    @(posedge clk);
    #1;
    n_checks++;
    if (dut.PC.pc_out !== 32'd0 || dut.Register_File.register[8] !== 32'd0)
      $display("FAIL midrun_held_edge: got pc %h r8 %h expected 0 0",
               dut.PC.pc_out, dut.Register_File.register[8]);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step(1);
    n_checks++;
    if (dut.PC.pc_out !== 32'd4 || dut.Register_File.register[8] !== 32'h1234)
      $display("FAIL midrun_restart: got pc %h r8 %h expected 4 1234",
               dut.PC.pc_out, dut.Register_File.register[8]);
    else n_pass++;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0]  rs, rt, rd;
    logic [5:0]  fn;
    logic [31:0] w;
    rs = 5'($urandom_range(0, 7));
    rt = 5'($urandom_range(0, 7));
    rd = 5'($urandom_range(0, 7));
    case ($urandom_range(0, 4))
      0:       fn = 6'h20;
      1:       fn = 6'h22;
      2:       fn = 6'h24;
      3:       fn = 6'h25;
      default: fn = 6'h2A;
    endcase
    case ($urandom_range(0, 11))
      0, 1:       w = i_ins(6'h08, rs, rt, 16'($urandom));
      2, 3, 4, 5: w = r_ins(fn, rs, rt, rd);
      6:          w = i_ins(6'h23, 5'd0, rt, 16'($urandom_range(0, 35) * 4 + $urandom_range(0, 3)));
      7, 8:       w = i_ins(6'h2B, 5'd0, rt, 16'($urandom_range(0, 35) * 4 + $urandom_range(0, 3)));
      9:          w = i_ins(6'h04, rs, rt, 16'($urandom_range(0, 6)) - 16'd3);
      10:         w = j_ins(26'($urandom_range(0, 50)));
      default:    w = $urandom;
    endcase
    return w;
  endfunction

  task automatic test_random();
    int bad;
    for (int p = 0; p < 4; p++) begin
      clear_prog();
      for (int i = 0; i < 48; i++) prog_mem[i] = rand_instr();
      load_and_restart();
      for (int c = 0; c < 80; c++) begin
        step(1);
        n_checks++;
        if (dut.PC.pc_out !== m_pc)
          $display("FAIL rand_pc prog%0d cyc%0d: got %h expected %h", p, c, dut.PC.pc_out, m_pc);
        else n_pass++;
        bad = -1;
        for (int i = 0; i < 32; i++)
          if (dut.Register_File.register[i] !== m_reg[i]) bad = i;
        n_checks++;
        if (bad >= 0)
          $display("FAIL rand_reg prog%0d cyc%0d r%0d: got %h expected %h", p, c, bad,
                   dut.Register_File.register[bad], m_reg[bad]);
        else n_pass++;
      end
      bad = -1;
      for (int i = 0; i < 128; i++)
        if (dut.Data_Memory.memory[i] !== m_mem[i]) bad = i;
      n_checks++;
      if (bad >= 0)
        $display("FAIL rand_mem prog%0d byte%0d: got %h expected %h", p, bad,
                 dut.Data_Memory.memory[bad], m_mem[bad]);
      else n_pass++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_arith();
    test_logic_nop();
    test_mem();
    test_branch_jump();
    test_midrun_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
